seven_segment_scanner: RTL and testbench

Parametrised multiplexed driver for an N-digit common-anode seven-segment display. It adds full hex decode, per-digit decimal point, blanking, blinking and leading-zero suppression. Inputs are snapshotted once per scan frame so a digit never tears mid-frame. It sits between the cart's status/sensor logic and the board display pins.

---
 rtl/seg_pkg.sv | 14 +
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seven_segment_scanner.sv | 119 +++++++++++
 tb/tb_seven_segment_scanner.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment constants: active-low hex font and the all-segments-off pattern.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Index = hex value; bit order {g,f,e,d,c,b,a}, 0 = segment lit.
  localparam logic [6:0] SEG_FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_FONT[nibble];

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit common-anode seven-segment driver with per-frame input
// snapshot, decimal points, blanking, blinking and leading-zero suppression.
module seven_segment_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 65536,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] nums,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lz_en,
  output logic [6:0]              display,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic                    frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           blink_cnt;
  logic                    phase;
  logic [4*NUM_DIGITS-1:0] snap_nums;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blank;
  logic [NUM_DIGITS-1:0]   snap_blink;
  logic                    snap_lz;

  logic                    tick;
  logic                    frame_tick;
  logic [NUM_DIGITS-1:0]   lz_sup;
  logic                    any_nz;
  logic [3:0]              cur_nib;
  logic [6:0]              dec_seg;
  logic                    digit_off;

  assign tick       = (prescaler == PRE_MAX);
  assign frame_tick = tick && (idx == IDX_MAX);

  // Scan timing, frame snapshot and blink phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler   <= '0;
      idx         <= IDX_MAX;
      blink_cnt   <= '0;
      phase       <= 1'b0;
      snap_nums   <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
      snap_blink  <= '0;
      snap_lz     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_tick;
      prescaler   <= tick ? '0 : prescaler + PW'(1);
      if (tick) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
      end
      if (frame_tick) begin
        snap_nums  <= nums;
        snap_dp    <= dp_in;
        snap_blank <= blank;
        snap_blink <= blink;
        snap_lz    <= lz_en;
        if (blink_cnt == BLINK_MAX) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  // Walk from the most significant digit down; a digit stays suppressed only
  // while every nibble at or above it is zero. Digit 0 always shows.
  always_comb begin
    lz_sup = '0;
    any_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      any_nz    = any_nz | (snap_nums[4*i +: 4] != 4'h0);
      lz_sup[i] = snap_lz && !any_nz && (i != 0);
    end
  end

  assign cur_nib   = snap_nums[4*int'(idx) +: 4];
  assign digit_off = snap_blank[idx] | (snap_blink[idx] & phase) | lz_sup[idx];

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // Output pins follow idx/snapshot by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit   <= '1;
      display <= SEG_OFF;
      dp      <= 1'b1;
    end else begin
      digit   <= ~(NUM_DIGITS'(1) << idx);
      display <= digit_off ? SEG_OFF : dec_seg;
      dp      <= digit_off | ~snap_dp[idx];
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seven_segment_scanner;

  localparam int N = 4;

  localparam logic [6:0] FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] OFF = 7'b1111111;

  logic         clk;
  logic         rst;
  logic [15:0]  nums;
  logic [3:0]   dp_in;
  logic [3:0]   blank;
  logic [3:0]   blink;
  logic         lz_en;
  logic [6:0]   display;
  logic         dp;
  logic [3:0]   digit;
  logic         frame_start;

  int vectors;
  int miscompares;

  seven_segment_scanner #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .nums        (nums),
    .dp_in       (dp_in),
    .blank       (blank),
    .blink       (blink),
    .lz_en       (lz_en),
    .display     (display),
    .dp          (dp),
    .digit       (digit),
    .frame_start (frame_start)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns at the negedge where frame_start is high; cycles = negedges waited.
  task automatic sync_frame(output bit found, output int cycles);
    found  = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(negedge clk);
      if (frame_start) begin
        found  = 1'b1;
        cycles = i;
      end
    end
  endtask

  task automatic set_inputs(input logic [15:0] n, input logic [3:0] d, input logic [3:0] bl,
                            input logic [3:0] bk, input logic lz);
    nums  = n;
    dp_in = d;
    blank = bl;
    blink = bk;
    lz_en = lz;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (digit !== 4'b1111) begin
      miscompares++; $display("FAIL reset_digit got %b want 1111", digit);
    end
    vectors++;
    if (display !== OFF) begin
      miscompares++; $display("FAIL reset_display got %b want %b", display, OFF);
    end
    vectors++;
    if (dp !== 1'b1) begin
      miscompares++; $display("FAIL reset_dp got %b want 1", dp);
    end
    vectors++;
    if (frame_start !== 1'b0) begin
      miscompares++; $display("FAIL reset_frame_start got %b want 0", frame_start);
    end
  endtask

  // Release reset with 1234 and walk the first frame.
  task automatic test_first_frame;
    bit found;
    int cyc;
    logic [6:0] exp_d [4];
    exp_d = '{FONT[4], FONT[3], FONT[2], FONT[1]};
    set_inputs(16'h1234, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    sync_frame(found, cyc);
    vectors++;
    if (!found || cyc != 4) begin
      miscompares++; $display("FAIL first_frame_start found %0d after %0d cycles want 4", found, cyc);
    end
    for (int k = 0; k < N; k++) begin
      repeat ((k == 0) ? 2 : 4) @(negedge clk);
      vectors++;
      if (digit !== ~(4'b0001 << k) || display !== exp_d[k] || dp !== 1'b1) begin
        miscompares++;
        $display("FAIL first_frame slot%0d got %b/%b/%b want %b/%b/1", k, digit, display, dp,
                 ~(4'b0001 << k), exp_d[k]);
      end
    end
  endtask

  task automatic test_hex_dp;
    bit found;
    int cyc;
    logic [6:0] exp_d [4];
    logic [3:0] exp_dp;
    exp_d  = '{FONT[13], FONT[12], FONT[11], FONT[10]};
    exp_dp = 4'b1101;
    set_inputs(16'hABCD, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    sync_frame(found, cyc);
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL hex_dp_sync no frame_start within 40 cycles");
    end
    for (int k = 0; k < N; k++) begin
      repeat ((k == 0) ? 2 : 4) @(negedge clk);
      vectors++;
      if (digit !== ~(4'b0001 << k) || display !== exp_d[k] || dp !== exp_dp[k]) begin
        miscompares++;
        $display("FAIL hex_dp slot%0d got %b/%b/%b want %b/%b/%b", k, digit, display, dp,
                 ~(4'b0001 << k), exp_d[k], exp_dp[k]);
      end
    end
  endtask

  // Three frames: 0005 with all dp set, 0100, then 0000.
  task automatic test_lz;
    bit found;
    int cyc;
    logic [15:0] vec_n [3];
    logic [3:0]  vec_dp [3];
    logic [6:0]  exp_d [3][4];
    logic [3:0]  exp_dp [3];
    vec_n  = '{16'h0005, 16'h0100, 16'h0000};
    vec_dp = '{4'b1111, 4'b0000, 4'b0000};
    exp_d  = '{'{FONT[5], OFF, OFF, OFF},
               '{FONT[0], FONT[0], FONT[1], OFF},
               '{FONT[0], OFF, OFF, OFF}};
    exp_dp = '{4'b1110, 4'b1111, 4'b1111};
    for (int f = 0; f < 3; f++) begin
      set_inputs(vec_n[f], vec_dp[f], 4'b0000, 4'b0000, 1'b1);
      sync_frame(found, cyc);
      vectors++;
      if (!found) begin
        miscompares++; $display("FAIL lz_sync frame%0d no frame_start", f);
      end
      for (int k = 0; k < N; k++) begin
        repeat ((k == 0) ? 2 : 4) @(negedge clk);
        vectors++;
        if (digit !== ~(4'b0001 << k) || display !== exp_d[f][k] || dp !== exp_dp[f][k]) begin
          miscompares++;
          $display("FAIL lz frame%0d slot%0d got %b/%b/%b want %b/%b/%b", f, k, digit, display,
                   dp, ~(4'b0001 << k), exp_d[f][k], exp_dp[f][k]);
        end
      end
    end
  endtask

  task automatic test_blank;
    bit found;
    int cyc;
    logic [6:0] exp_d [4];
    logic [3:0] exp_dp;
    exp_d  = '{FONT[8], FONT[7], OFF, FONT[5]};
    exp_dp = 4'b0100;
    set_inputs(16'h5678, 4'b1111, 4'b0100, 4'b0000, 1'b0);
    sync_frame(found, cyc);
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL blank_sync no frame_start");
    end
    for (int k = 0; k < N; k++) begin
      repeat ((k == 0) ? 2 : 4) @(negedge clk);
      vectors++;
      if (digit !== ~(4'b0001 << k) || display !== exp_d[k] || dp !== exp_dp[k]) begin
        miscompares++;
        $display("FAIL blank slot%0d got %b/%b/%b want %b/%b/%b", k, digit, display, dp,
                 ~(4'b0001 << k), exp_d[k], exp_dp[k]);
      end
    end
  endtask

  // From reset: frame 1 phase 0, then the phase toggles every 2 frames.
  task automatic test_blink;
    bit found;
    int cyc;
    bit vis [6];
    vis = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    rst = 1'b0;
    set_inputs(16'h8888, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int f = 0; f < 6; f++) begin
      sync_frame(found, cyc);
      vectors++;
      if (!found) begin
        miscompares++; $display("FAIL blink_sync frame%0d no frame_start", f);
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (digit !== 4'b1110 || display !== (vis[f] ? FONT[8] : OFF)) begin
        miscompares++;
        $display("FAIL blink_d0 frame%0d got %b/%b want 1110/%b", f, digit, display,
                 vis[f] ? FONT[8] : OFF);
      end
      repeat (4) @(negedge clk);
      vectors++;
      if (digit !== 4'b1101 || display !== FONT[8]) begin
        miscompares++;
        $display("FAIL blink_d1 frame%0d got %b/%b want 1101/%b", f, digit, display, FONT[8]);
      end
    end
  endtask

  // nums changes while digit 2 is on the pins; the frame must not tear.
  task automatic test_no_tear;
    bit found;
    int cyc;
    set_inputs(16'h1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    sync_frame(found, cyc);
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL tear_sync no frame_start");
    end
    for (int k = 0; k < N; k++) begin
      repeat ((k == 0) ? 2 : 4) @(negedge clk);
      if (k == 2) nums = 16'h2222;
      vectors++;
      if (digit !== ~(4'b0001 << k) || display !== FONT[1]) begin
        miscompares++;
        $display("FAIL tear_old slot%0d got %b/%b want %b/%b", k, digit, display,
                 ~(4'b0001 << k), FONT[1]);
      end
    end
    sync_frame(found, cyc);
    vectors++;
    if (!found || cyc != 2) begin
      miscompares++; $display("FAIL tear_resync found %0d after %0d cycles want 2", found, cyc);
    end
    for (int k = 0; k < N; k++) begin
      repeat ((k == 0) ? 2 : 4) @(negedge clk);
      vectors++;
      if (digit !== ~(4'b0001 << k) || display !== FONT[2]) begin
        miscompares++;
        $display("FAIL tear_new slot%0d got %b/%b want %b/%b", k, digit, display,
                 ~(4'b0001 << k), FONT[2]);
      end
    end
  endtask

  task automatic test_mid_reset;
    bit found;
    int cyc;
    set_inputs(16'h9876, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    sync_frame(found, cyc);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    vectors++;
    if (digit !== 4'b1111 || display !== OFF || dp !== 1'b1 || frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got %b/%b/%b/%b want 1111/%b/1/0", digit, display, dp,
               frame_start, OFF);
    end
    @(negedge clk);
    rst = 1'b1;
    sync_frame(found, cyc);
    vectors++;
    if (!found || cyc != 4) begin
      miscompares++; $display("FAIL restart_frame found %0d after %0d cycles want 4", found, cyc);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (digit !== 4'b1110 || display !== FONT[6] || dp !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_slot0 got %b/%b/%b want 1110/%b/0", digit, display, dp, FONT[6]);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    set_inputs(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    test_reset();
    test_first_frame();
    test_hex_dp();
    test_lz();
    test_blank();
    test_blink();
    test_no_tear();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
